// File: rtl/mem_dump_reader.sv
// Sequential memory dump engine: reads an inclusive address range one word at a
// time over a shared memory port and presents each word on a valid/ready output.
`timescale 1ns/1ps

// state   | meaning
// IDLE    | waiting for start; range checked here
// ISSUE   | address driven, memory read launched
// CAPTURE | memory data arrives, registered at closing edge
// PRESENT | word offered downstream until accepted
// DONE    | one-cycle completion pulse
module mem_dump_reader #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              main_clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic              mem_en,
    output logic              read_write,
    output logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] read_out_data,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        PRESENT,
        DONE
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W-1:0] end_q;

    logic launch;
    logic reject;
    logic cancel;
    logic handshake;
    logic last_word;

    assign launch    = (state == IDLE) && start && (start_addr <= end_addr);
    assign reject    = (state == IDLE) && start && (start_addr > end_addr);
    assign cancel    = (state != IDLE) && abort;
    assign handshake = (state == PRESENT) && out_valid && out_ready && !abort;
    assign last_word = (cur == end_q);

    always_ff @(posedge main_clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (launch) next_state = ISSUE;
            ISSUE:   next_state = CAPTURE;
            CAPTURE: next_state = PRESENT;
            PRESENT: if (handshake) next_state = last_word ? DONE : ISSUE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (cancel) next_state = IDLE;
    end

    // cur stops at end_q on the last word, so an all-ones range never wraps
    always_ff @(posedge main_clk or posedge reset) begin
        if (reset) begin
            cur       <= '0;
            end_q     <= '0;
            out_data  <= '0;
            out_addr  <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= reject;
            if (launch) begin
                cur   <= start_addr;
                end_q <= end_addr;
            end
            if (state == CAPTURE && !abort) begin
                out_data  <= read_out_data;
                out_addr  <= cur;
                out_valid <= 1'b1;
            end
            if (handshake) begin
                out_valid <= 1'b0;
                if (!last_word) cur <= cur + 1'b1;
            end
            if (cancel) out_valid <= 1'b0;
        end
    end

    // address follows cur, which only moves on launch or accepted word
    assign mem_en     = (state == ISSUE) || (state == CAPTURE);
    assign read_write = 1'b0;
    assign address    = cur;
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

endmodule

// File: tb/tb_mem_dump_reader.sv
// Self-checking bench for mem_dump_reader: synchronous-read memory model,
// randomized backpressure and address noise, expectations from range arithmetic.
`timescale 1ns/1ps

module tb_mem_dump_reader;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    logic              main_clk = 1'b0;
    logic              reset;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] end_addr;
    logic              mem_en;
    logic              read_write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] read_out_data;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;
    logic              err;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int errors = 0;
    int checks = 0;

    mem_dump_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .main_clk      (main_clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .start_addr    (start_addr),
        .end_addr      (end_addr),
        .mem_en        (mem_en),
        .read_write    (read_write),
        .address       (address),
        .read_out_data (read_out_data),
        .out_data      (out_data),
        .out_addr      (out_addr),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 main_clk = ~main_clk;

    // one-cycle synchronous read memory
    always @(posedge main_clk or posedge reset) begin
        if (reset) read_out_data <= '0;
        else if (mem_en && !read_write) read_out_data <= mem[address];
    end

    // Runs one dump of s..e and checks it against the range model:
    // words s..e in order, 3 cycles/word plus stalls, one done, busy = 3n+1+stalls.
    task automatic run_dump(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e,
                            input int stall_word, input int stall_len, input bit rand_ready);
        int n, words, stalls, busy_cyc, dones, stall_left, last_rise;
        bit finished, accept, prev_valid, prev_accept;
        logic [DATA_W-1:0] prev_data;
        logic [ADDR_W-1:0] prev_oaddr, prev_address, exp_a;
        n = int'(e) - int'(s) + 1;
        words = 0; stalls = 0; busy_cyc = 0; dones = 0; last_rise = 0;
        stall_left = stall_len; finished = 0; prev_valid = 0; prev_accept = 1;
        prev_data = '0; prev_oaddr = '0;
        @(negedge main_clk);
        start_addr = s; end_addr = e; start = 1'b1; out_ready = 1'b1;
        prev_address = address;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            @(negedge main_clk);
            exp_a = ADDR_W'(int'(s) + words);
            checks++;
            if (read_write !== 1'b0) begin
                errors++; $display("FAIL read_write: got %b expected 0", read_write);
            end
            checks++;
            if (mem_en && address !== exp_a) begin
                errors++; $display("FAIL address: got %h expected %h", address, exp_a);
            end else if (!mem_en && address !== prev_address) begin
                errors++; $display("FAIL address_hold: got %h expected %h", address, prev_address);
            end
            if (out_valid) begin
                checks++;
                if (mem_en !== 1'b0) begin
                    errors++; $display("FAIL mem_en_stall: got %b expected 0", mem_en);
                end
            end
            if (busy) busy_cyc++;
            if (done) begin
                dones++;
                checks++;
                if (words !== n) begin
                    errors++; $display("FAIL done_early: words %0d expected %0d", words, n);
                end
            end
            if (out_valid) begin
                if (prev_valid && !prev_accept) begin
                    checks++;
                    if (out_data !== prev_data || out_addr !== prev_oaddr) begin
                        errors++;
                        $display("FAIL hold: got %h@%h expected %h@%h", out_data, out_addr, prev_data, prev_oaddr);
                    end
                end else begin
                    checks++;
                    if (out_addr !== exp_a || out_data !== mem[exp_a]) begin
                        errors++;
                        $display("FAIL word%0d: got %h@%h expected %h@%h", words, out_data, out_addr, mem[exp_a], exp_a);
                    end
                    if (words > 0 && !rand_ready && stall_len == 0) begin
                        checks++;
                        if (cyc - last_rise !== 3) begin
                            errors++; $display("FAIL spacing: got %0d expected 3", cyc - last_rise);
                        end
                    end
                    last_rise = cyc;
                end
                if (rand_ready) accept = ($urandom_range(0, 2) != 0);
                else if (words == stall_word && stall_left > 0) begin
                    accept = 0; stall_left--;
                end else accept = 1;
                if (accept) words++;
                else stalls++;
            end else begin
                accept = 1;
            end
            out_ready = accept;
            prev_valid = out_valid; prev_accept = accept;
            prev_data = out_data; prev_oaddr = out_addr; prev_address = address;
            if (!busy) begin
                finished = 1; start = 1'b0;
            end else begin
                // noise that a busy dump must ignore
                start = 1'($urandom_range(0, 1));
                start_addr = ADDR_W'($urandom_range(0, 4095));
                end_addr = ADDR_W'($urandom_range(0, 4095));
            end
        end
        start = 1'b0; out_ready = 1'b1;
        checks++;
        if (!finished) begin
            errors++; $display("FAIL timeout: dump %h..%h did not finish", s, e);
        end
        checks++;
        if (words !== n) begin
            errors++; $display("FAIL word_count: got %0d expected %0d", words, n);
        end
        checks++;
        if (dones !== 1) begin
            errors++; $display("FAIL done_count: got %0d expected 1", dones);
        end
        checks++;
        if (busy_cyc !== 3 * n + 1 + stalls) begin
            errors++; $display("FAIL busy_cycles: got %0d expected %0d", busy_cyc, 3 * n + 1 + stalls);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        start_addr = '0; end_addr = '0;
        #2;
        checks++;
        if ({mem_en, read_write, out_valid, busy, done, err} !== 6'b0 ||
            address !== '0 || out_data !== '0 || out_addr !== '0) begin
            errors++;
            $display("FAIL reset_state: ctrl %b addr %h data %h oaddr %h expected zeros",
                     {mem_en, read_write, out_valid, busy, done, err}, address, out_data, out_addr);
        end
        repeat (2) @(negedge main_clk);
        reset = 1'b0;
        repeat (2) @(negedge main_clk);
        checks++;
        if (busy !== 1'b0 || mem_en !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: busy %b mem_en %b expected 0 0", busy, mem_en);
        end
    endtask

    task automatic test_two_words;
        run_dump(12'h001, 12'h002, 0, 0, 0);
    endtask

    task automatic test_single_word;
        run_dump(12'h007, 12'h007, 0, 0, 0);
    endtask

    task automatic test_stall;
        run_dump(12'h001, 12'h002, 0, 5, 0);
    endtask

    task automatic test_top_of_memory;
        run_dump(12'hFFE, 12'hFFF, 0, 0, 0);
        checks++;
        if (address !== 12'hFFF) begin
            errors++; $display("FAIL no_wrap: got %h expected fff", address);
        end
    endtask

    task automatic test_err;
        @(negedge main_clk);
        start_addr = 12'h008; end_addr = 12'h007; start = 1'b1;
        @(negedge main_clk);
        start = 1'b0;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || mem_en !== 1'b0) begin
            errors++; $display("FAIL err_pulse: err %b busy %b mem_en %b expected 1 0 0", err, busy, mem_en);
        end
        @(negedge main_clk);
        checks++;
        if (err !== 1'b0 || busy !== 1'b0 || mem_en !== 1'b0) begin
            errors++; $display("FAIL err_clear: err %b busy %b mem_en %b expected 0 0 0", err, busy, mem_en);
        end
    endtask

    task automatic test_abort;
        bit seen;
        @(negedge main_clk);
        start_addr = 12'h001; end_addr = 12'h002; start = 1'b1; out_ready = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge main_clk);
            start = 1'b0;
            if (out_valid) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL abort_setup: out_valid never rose");
        end
        abort = 1'b1; out_ready = 1'b1;
        @(negedge main_clk);
        abort = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL abort: out_valid %b busy %b expected 0 0", out_valid, busy);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge main_clk);
            checks++;
            if (done !== 1'b0 || mem_en !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL abort_quiet: done %b mem_en %b busy %b expected 0 0 0", done, mem_en, busy);
            end
        end
    endtask

    task automatic test_reset_mid_dump;
        @(negedge main_clk);
        start_addr = 12'h001; end_addr = 12'h002; start = 1'b1; out_ready = 1'b1;
        @(negedge main_clk);
        start = 1'b0;
        @(negedge main_clk);
        checks++;
        if (mem_en !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL capture_setup: mem_en %b valid %b busy %b expected 1 0 1", mem_en, out_valid, busy);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({mem_en, read_write, out_valid, busy, done, err} !== 6'b0 ||
            address !== '0 || out_data !== '0 || out_addr !== '0) begin
            errors++;
            $display("FAIL async_reset: ctrl %b addr %h data %h oaddr %h expected zeros",
                     {mem_en, read_write, out_valid, busy, done, err}, address, out_data, out_addr);
        end
        @(negedge main_clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge main_clk);
            checks++;
            if (busy !== 1'b0 || mem_en !== 1'b0 || out_valid !== 1'b0) begin
                errors++; $display("FAIL wait_idle: busy %b mem_en %b valid %b expected 0 0 0", busy, mem_en, out_valid);
            end
        end
        run_dump(12'h001, 12'h002, 0, 0, 0);
    endtask

    task automatic test_random_dumps;
        logic [ADDR_W-1:0] s;
        for (int k = 0; k < 8; k++) begin
            s = ADDR_W'($urandom_range(0, 4090));
            run_dump(s, s + ADDR_W'($urandom_range(0, 4)), 0, 0, 1);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = $urandom;
        mem[12'h001] = 32'h18007003;
        mem[12'h002] = 32'h18008004;
        mem[12'h007] = 32'h0000000A;
        mem[12'h008] = 32'h000000FF;
        test_reset;
        test_two_words;
        test_single_word;
        test_stall;
        test_err;
        test_top_of_memory;
        test_abort;
        test_reset_mid_dump;
        test_random_dumps;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
